// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier, one partial product per clock, unsigned or
// two's-complement per operation, with full/truncated product and overflow flag.
module seq_multiplier #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic           is_signed,
   output logic           out_valid,
   output logic [2*N-1:0] p_full,
   output logic [N-1:0]   p,
   output logic           v,
   output logic [1:0]     state_dbg
);

   // Handshake: an operation is accepted on a rising edge where in_valid && in_ready;
   // in_ready is high only in IDLE, and out_valid is a one-cycle pulse in DONE.

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   localparam int CW = $clog2(N + 1);
   localparam int IW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N);

   state_t           state_q, state_d;
   logic [N-1:0]     a_mag_q, b_mag_q;
   logic             neg_q, sgn_q;
   logic [2*N-1:0]   acc_q;
   logic [CW-1:0]    cnt_q;
   logic [2*N-1:0]   p_full_q;
   logic             v_q;

   logic [N-1:0]     a_neg, b_neg, a_in_mag, b_in_mag;
   logic [IW-1:0]    cnt_idx;
   logic [2*N-1:0]   part, prod;
   logic             v_calc;

   // |x| taken as an N-bit unsigned value, so the most negative operand maps to 2^(N-1)
   assign a_neg    = -a;
   assign b_neg    = -b;
   assign a_in_mag = (is_signed && a[N-1]) ? a_neg : a;
   assign b_in_mag = (is_signed && b[N-1]) ? b_neg : b;

   assign cnt_idx = cnt_q[IW-1:0];
   assign part    = b_mag_q[cnt_idx] ? ({{N{1'b0}}, a_mag_q} << cnt_q) : '0;
   assign prod    = neg_q ? -acc_q : acc_q;

   always_comb begin
      v_calc = 1'b0;
      if (sgn_q) v_calc = !((&prod[2*N-1:N-1]) || !(|prod[2*N-1:N-1]));
      else       v_calc = |prod[2*N-1:N];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            if (cnt_q == LAST) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The final RUN cycle (cnt == N) applies the sign and loads the result registers
   // so they are already valid in the DONE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_mag_q  <= '0;
         b_mag_q  <= '0;
         neg_q    <= 1'b0;
         sgn_q    <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
         p_full_q <= '0;
         v_q      <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_mag_q <= a_in_mag;
                  b_mag_q <= b_in_mag;
                  neg_q   <= is_signed & (a[N-1] ^ b[N-1]);
                  sgn_q   <= is_signed;
                  acc_q   <= '0;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               if (cnt_q == LAST) begin
                  p_full_q <= prod;
                  v_q      <= v_calc;
               end else begin
                  acc_q <= acc_q + part;
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: cnt_q <= '0;
            default: cnt_q <= '0;
         endcase
      end
   end

   assign p_full    = p_full_q;
   assign p         = p_full_q[N-1:0];
   assign v         = v_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at N=4: vector table plus busy-input and
// mid-operation reset sequences.
module tb_seq_multiplier;

   localparam int N = 4;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           is_signed;
   logic           out_valid;
   logic [2*N-1:0] p_full;
   logic [N-1:0]   p;
   logic           v;
   logic [1:0]     state_dbg;

   int total;
   int bad;

   seq_multiplier #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .is_signed (is_signed),
      .out_valid (out_valid),
      .p_full    (p_full),
      .p         (p),
      .v         (v),
      .state_dbg (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]   va;
      logic [N-1:0]   vb;
      logic           vs;
      logic [2*N-1:0] exp_full;
      logic [N-1:0]   exp_p;
      logic           exp_v;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // Waits for IDLE, presents one operation, and returns its result and latency
   // in edges after the accepting edge (-1 if out_valid never came).
   task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_b, input logic ts,
                         output logic [2*N-1:0] f, output logic [N-1:0] pp,
                         output logic vv, output int lat);
      int w;
      int k;
      w = 0;
      while (!in_ready && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      chk("ready_before_op", 16'(in_ready), 16'd1);
      a = ta; b = tb_b; is_signed = ts; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = -1;
      k = 0;
      while (lat < 0 && k < 20) begin
         @(posedge clk); #1;
         k++;
         if (out_valid) lat = k;
      end
      f = p_full; pp = p; vv = v;
   endtask

   initial begin
      logic [2*N-1:0] f, held;
      logic [N-1:0]   pp;
      logic           vv;
      int             lat;
      int             seen;
      int             k;

      total = 0;
      bad   = 0;

      vecs[0]  = '{4'd3,  4'd5,  1'b0, 8'h0F, 4'hF, 1'b0};
      vecs[1]  = '{4'd15, 4'd15, 1'b0, 8'hE1, 4'h1, 1'b1};
      vecs[2]  = '{4'hE,  4'd3,  1'b1, 8'hFA, 4'hA, 1'b0};
      vecs[3]  = '{4'hD,  4'd5,  1'b1, 8'hF1, 4'h1, 1'b1};
      vecs[4]  = '{4'h8,  4'h8,  1'b1, 8'h40, 4'h0, 1'b1};
      vecs[5]  = '{4'h8,  4'd1,  1'b1, 8'hF8, 4'h8, 1'b0};
      vecs[6]  = '{4'd0,  4'd9,  1'b0, 8'h00, 4'h0, 1'b0};
      vecs[7]  = '{4'd6,  4'd7,  1'b0, 8'h2A, 4'hA, 1'b1};
      vecs[8]  = '{4'd7,  4'hF,  1'b1, 8'hF9, 4'h9, 1'b0};
      vecs[9]  = '{4'd0,  4'hB,  1'b1, 8'h00, 4'h0, 1'b0};
      vecs[10] = '{4'd4,  4'd4,  1'b0, 8'h10, 4'h0, 1'b1};
      vecs[11] = '{4'd3,  4'd2,  1'b1, 8'h06, 4'h6, 1'b0};
      vecs[12] = '{4'd4,  4'd2,  1'b1, 8'h08, 4'h8, 1'b1};
      vecs[13] = '{4'hF,  4'hF,  1'b1, 8'h01, 4'h1, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_in_ready",  16'(in_ready),  16'd1);
      chk("rst_out_valid", 16'(out_valid), 16'd0);
      chk("rst_p_full",    16'(p_full),    16'd0);
      chk("rst_p",         16'(p),         16'd0);
      chk("rst_v",         16'(v),         16'd0);
      chk("rst_state",     16'(state_dbg), 16'd0);

      for (int i = 0; i < 14; i++) begin
         run_op(vecs[i].va, vecs[i].vb, vecs[i].vs, f, pp, vv, lat);
         chk($sformatf("vec%0d_latency", i), 16'(lat), 16'd5);
         chk($sformatf("vec%0d_p_full", i), 16'(f), 16'(vecs[i].exp_full));
         chk($sformatf("vec%0d_p", i), 16'(pp), 16'(vecs[i].exp_p));
         chk($sformatf("vec%0d_v", i), 16'(vv), 16'(vecs[i].exp_v));
         @(posedge clk); #1;
         chk($sformatf("vec%0d_pulse_one_cycle", i), 16'(out_valid), 16'd0);
         chk($sformatf("vec%0d_hold_idle", i), 16'(p_full), 16'(vecs[i].exp_full));
      end

      // Busy: operands change and in_valid stays high throughout RUN.
      held = p_full;
      a = 4'd3; b = 4'd5; is_signed = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 4'd15; b = 4'd15;
      @(posedge clk); #1;
      chk("busy_in_ready", 16'(in_ready), 16'd0);
      chk("busy_hold_run", 16'(p_full), 16'(held));
      k = 0;
      while (!out_valid && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk("busy_first_done", 16'(out_valid), 16'd1);
      chk("busy_first_p_full", 16'(p_full), 16'h0F);
      @(posedge clk); #1;
      chk("busy_idle_ready", 16'(in_ready), 16'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("busy_second_accepted", 16'(in_ready), 16'd0);
      lat = -1;
      k = 0;
      while (lat < 0 && k < 20) begin
         @(posedge clk); #1;
         k++;
         if (out_valid) lat = k;
      end
      chk("busy_second_latency", 16'(lat), 16'd5);
      chk("busy_second_p_full", 16'(p_full), 16'hE1);
      chk("busy_second_v", 16'(v), 16'd1);
      @(posedge clk); #1;

      // Reset pulled mid-RUN abandons the operation.
      a = 4'd9; b = 4'd9; is_signed = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_p_full", 16'(p_full), 16'd0);
      chk("midrst_in_ready", 16'(in_ready), 16'd1);
      chk("midrst_out_valid", 16'(out_valid), 16'd0);
      chk("midrst_v", 16'(v), 16'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("midrst_no_pulse", 16'(seen), 16'd0);
      chk("midrst_p_full_after", 16'(p_full), 16'd0);
      run_op(4'd6, 4'd7, 1'b0, f, pp, vv, lat);
      chk("after_rst_latency", 16'(lat), 16'd5);
      chk("after_rst_p_full", 16'(f), 16'd42);
      chk("after_rst_v", 16'(vv), 16'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
